// File: rtl/macro_reduction_pipe_if.sv
// Handshake bundle for macro_reduction_pipe: operand vector in, reduced word out.
// master = producer/consumer side, slave = the reduction pipe itself.
interface macro_reduction_pipe_if #(
  parameter int WIDTH = 1,
  parameter int COUNT = 1
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH*COUNT-1:0]   d;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         q;

  modport master (
    output in_valid, d, out_ready,
    input  in_ready, out_valid, q
  );

  modport slave (
    input  in_valid, d, out_ready,
    output in_ready, out_valid, q
  );
endinterface

// File: rtl/macro_reduction_pipe.sv
// Pipelined multi-operand bitwise reduction (OR / AND / XOR) built from a
// registered tree of FANIN-input nodes with valid/ready back-pressure.
// Optional feature: define MACRO_REDUCTION_PIPE_FLUSH_EN to get a synchronous
// flush port that clears every stage valid bit (stage data is left alone).
module macro_reduction_pipe #(
  parameter int INPUT_WIDTH = 1,
  parameter int INPUT_COUNT = 1,
  parameter int FANIN       = 4,
  parameter int OP          = 0
) (
  input  logic clk,
  input  logic resetn,
`ifdef MACRO_REDUCTION_PIPE_FLUSH_EN
  input  logic flush,
`endif
  macro_reduction_pipe_if.slave bus
);

  // Words held after k levels of reduction (k = 0 is the raw operand count).
  function automatic int level_count(input int k);
    int c;
    c = INPUT_COUNT;
    for (int i = 0; i < k; i++) c = (c + FANIN - 1) / FANIN;
    return c;
  endfunction

  // Number of levels needed to reach one word; a single operand still gets
  // one register stage.
  function automatic int stage_count(input int count);
    int c;
    int n;
    c = count;
    n = 0;
    while (c > 1 && n < 64) begin
      c = (c + FANIN - 1) / FANIN;
      n++;
    end
    return (n < 1) ? 1 : n;
  endfunction

  localparam int   S     = stage_count(INPUT_COUNT);
  // Padding value that leaves the reduction unchanged.
  localparam logic IDENT = (OP == 1) ? 1'b1 : 1'b0;

  if (OP < 0 || OP > 2) begin : g_bad_op
    $error("macro_reduction_pipe: OP must be 0 (OR), 1 (AND) or 2 (XOR)");
  end
  if (FANIN < 2 || FANIN > 8) begin : g_bad_fanin
    $error("macro_reduction_pipe: FANIN must be within 2..8");
  end
  if (INPUT_COUNT < 1 || INPUT_COUNT > 256) begin : g_bad_count
    $error("macro_reduction_pipe: INPUT_COUNT must be within 1..256");
  end

  function automatic logic [INPUT_WIDTH-1:0] combine(
    input logic [INPUT_WIDTH-1:0] a,
    input logic [INPUT_WIDTH-1:0] b
  );
    case (OP)
      1:       return a & b;
      2:       return a ^ b;
      default: return a | b;
    endcase
  endfunction

  logic [S-1:0] v;
  logic [S-1:0] e;
  logic         flush_i;

`ifdef MACRO_REDUCTION_PIPE_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Ready chain: a stage may advance if it is empty or its successor advances,
  // so bubbles collapse even while the output is stalled.
  always_comb begin : ready_chain
    logic run;
    e   = '0;
    run = ~v[S-1] | bus.out_ready;
    e[S-1] = run;
    for (int k = S - 2; k >= 0; k--) begin
      run  = ~v[k] | run;
      e[k] = run;
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int CI = level_count(k);
    localparam int CO = level_count(k + 1);

    logic [CI*INPUT_WIDTH-1:0]       src;
    logic                            vin;
    logic [CO*FANIN*INPUT_WIDTH-1:0] padded;
    logic [CO*INPUT_WIDTH-1:0]       nxt;
    logic [CO*INPUT_WIDTH-1:0]       data;
    logic                            valid;

    if (k == 0) begin : g_first
      assign src = bus.d;
      assign vin = bus.in_valid;
    end else begin : g_next
      assign src = g_stage[k-1].data;
      assign vin = v[k-1];
    end

    // One node level: pad short groups with the identity, then fold each
    // group of FANIN consecutive words into one output word.
    always_comb begin : node_level
      logic [INPUT_WIDTH-1:0] acc;
      acc    = '0;
      padded = {(CO*FANIN*INPUT_WIDTH){IDENT}};
      padded[CI*INPUT_WIDTH-1:0] = src;
      nxt    = '0;
      for (int j = 0; j < CO; j++) begin
        acc = {INPUT_WIDTH{IDENT}};
        for (int f = 0; f < FANIN; f++) begin
          acc = combine(acc, padded[(j*FANIN+f)*INPUT_WIDTH +: INPUT_WIDTH]);
        end
        nxt[j*INPUT_WIDTH +: INPUT_WIDTH] = acc;
      end
    end

    // Stage data register; held while stalled or flushing.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        data <= '0;
      end else if (!flush_i && e[k]) begin
        data <= nxt;
      end
    end

    // Stage valid bit; flush wins over any advance.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        valid <= 1'b0;
      end else if (flush_i) begin
        valid <= 1'b0;
      end else if (e[k]) begin
        valid <= vin;
      end
    end

    assign v[k] = valid;
  end

  assign bus.in_ready  = e[0];
  assign bus.out_valid = v[S-1];
  assign bus.q         = g_stage[S-1].data;

endmodule

// File: tb/tb_macro_reduction_pipe.sv
// Directed bench for macro_reduction_pipe: OR/AND/XOR instances driven from a
// vector table, plus hand sequences for stall, reset and (optionally) flush.
module tb_macro_reduction_pipe;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic out_ready = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  macro_reduction_pipe_if #(.WIDTH(8), .COUNT(16)) if_or ();
  macro_reduction_pipe_if #(.WIDTH(4), .COUNT(5))  if_and ();
  macro_reduction_pipe_if #(.WIDTH(8), .COUNT(3))  if_xor ();

  assign if_or.out_ready  = out_ready;
  assign if_and.out_ready = out_ready;
  assign if_xor.out_ready = out_ready;

  macro_reduction_pipe #(.INPUT_WIDTH(8), .INPUT_COUNT(16), .FANIN(4), .OP(0)) u_or (
    .clk(clk),
    .resetn(resetn),
`ifdef MACRO_REDUCTION_PIPE_FLUSH_EN
    .flush(1'b0),
`endif
    .bus(if_or.slave)
  );

  macro_reduction_pipe #(.INPUT_WIDTH(4), .INPUT_COUNT(5), .FANIN(4), .OP(1)) u_and (
    .clk(clk),
    .resetn(resetn),
`ifdef MACRO_REDUCTION_PIPE_FLUSH_EN
    .flush(1'b0),
`endif
    .bus(if_and.slave)
  );

  macro_reduction_pipe #(.INPUT_WIDTH(8), .INPUT_COUNT(3), .FANIN(4), .OP(2)) u_xor (
    .clk(clk),
    .resetn(resetn),
`ifdef MACRO_REDUCTION_PIPE_FLUSH_EN
    .flush(1'b0),
`endif
    .bus(if_xor.slave)
  );

`ifdef MACRO_REDUCTION_PIPE_FLUSH_EN
  logic flush = 1'b0;
  macro_reduction_pipe_if #(.WIDTH(8), .COUNT(1)) if_fl ();
  assign if_fl.out_ready = out_ready;

  macro_reduction_pipe #(.INPUT_WIDTH(8), .INPUT_COUNT(1), .FANIN(4), .OP(0)) u_fl (
    .clk(clk),
    .resetn(resetn),
    .flush(flush),
    .bus(if_fl.slave)
  );
`endif

  typedef struct packed {
    logic [127:0] d_or;
    logic [7:0]   q_or;
    logic [19:0]  d_and;
    logic [3:0]   q_and;
    logic [23:0]  d_xor;
    logic [7:0]   q_xor;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // OR (S=2), AND (S=2, padded last group), XOR (S=1); hand-computed.
    tbl[0] = '{d_or: 128'h00000080_00000000_00000000_01000000, q_or: 8'h81,
               d_and: 20'h7FFFF, q_and: 4'h7,
               d_xor: 24'h040201, q_xor: 8'h07};
    tbl[1] = '{d_or: 128'h0, q_or: 8'h00,
               d_and: 20'hFFFFF, q_and: 4'hF,
               d_xor: 24'hF00FFF, q_xor: 8'h00};
    tbl[2] = '{d_or: 128'h01020408_00000000_10000000_00000020, q_or: 8'h3F,
               d_and: 20'hFFFF0, q_and: 4'h0,
               d_xor: 24'h000000, q_xor: 8'h00};
    tbl[3] = '{d_or: 128'h80, q_or: 8'h80,
               d_and: 20'hFEFDF, q_and: 4'hC,
               d_xor: 24'h8155AA, q_xor: 8'h7E};

    if_or.in_valid = 1'b0;  if_or.d = '0;
    if_and.in_valid = 1'b0; if_and.d = '0;
    if_xor.in_valid = 1'b0; if_xor.d = '0;
`ifdef MACRO_REDUCTION_PIPE_FLUSH_EN
    if_fl.in_valid = 1'b0;  if_fl.d = '0;
`endif

    // Reset state
    #12;
    check("rst_or_valid", if_or.out_valid, 0);
    check("rst_or_q", if_or.q, 0);
    check("rst_and_valid", if_and.out_valid, 0);
    check("rst_and_q", if_and.q, 0);
    check("rst_xor_valid", if_xor.out_valid, 0);
    check("rst_xor_q", if_xor.q, 0);
    step();
    resetn = 1'b1;
    step();
    check("idle_or_ready", if_or.in_ready, 1);
    check("idle_and_ready", if_and.in_ready, 1);
    check("idle_xor_ready", if_xor.in_ready, 1);

    // Back-to-back table stream at full rate; XOR shows after 1 edge,
    // OR and AND after 2 edges.
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        if_or.in_valid = 1'b1;  if_or.d = tbl[i].d_or;
        if_and.in_valid = 1'b1; if_and.d = tbl[i].d_and;
        if_xor.in_valid = 1'b1; if_xor.d = tbl[i].d_xor;
        check($sformatf("tbl%0d_or_ready", i), if_or.in_ready, 1);
      end else begin
        if_or.in_valid = 1'b0;
        if_and.in_valid = 1'b0;
        if_xor.in_valid = 1'b0;
      end
      step();
      if (i < 4) begin
        check($sformatf("tbl%0d_xor_valid", i), if_xor.out_valid, 1);
        check($sformatf("tbl%0d_xor_q", i), if_xor.q, tbl[i].q_xor);
      end else begin
        check($sformatf("tbl%0d_xor_valid", i), if_xor.out_valid, 0);
      end
      if (i == 0) begin
        check("tbl0_or_early", if_or.out_valid, 0);
        check("tbl0_and_early", if_and.out_valid, 0);
      end else begin
        check($sformatf("tbl%0d_or_valid", i - 1), if_or.out_valid, 1);
        check($sformatf("tbl%0d_or_q", i - 1), if_or.q, tbl[i-1].q_or);
        check($sformatf("tbl%0d_and_valid", i - 1), if_and.out_valid, 1);
        check($sformatf("tbl%0d_and_q", i - 1), if_and.q, tbl[i-1].q_and);
      end
    end
    step();
    check("drain_or_valid", if_or.out_valid, 0);
    check("drain_and_valid", if_and.out_valid, 0);

    // Back-pressure on the OR pipe: A and B absorbed, C and D refused.
    out_ready = 1'b0;
    if_or.in_valid = 1'b1; if_or.d = 128'h01;
    #1 check("bp_a_ready", if_or.in_ready, 1);
    step();
    if_or.d = 128'h02000000_00000000_00000000_00000000;
    check("bp_b_ready", if_or.in_ready, 1);
    step();
    check("bp_full_ready", if_or.in_ready, 0);
    check("bp_full_valid", if_or.out_valid, 1);
    check("bp_full_q", if_or.q, 8'h01);
    if_or.d = 128'h00000000_00000000_04000000_00000000;
    step();
    check("bp_c_ready", if_or.in_ready, 0);
    check("bp_c_q", if_or.q, 8'h01);
    if_or.d = 128'h00000000_00080000_00000000_00000000;
    step();
    check("bp_d_ready", if_or.in_ready, 0);
    check("bp_d_valid", if_or.out_valid, 1);
    check("bp_d_q", if_or.q, 8'h01);
    // Release while re-offering C: accept and drain in the same cycle.
    if_or.d = 128'h00000000_00000000_04000000_00000000;
    out_ready = 1'b1;
    #1 check("bp_release_ready", if_or.in_ready, 1);
    step();
    check("bp_out_b_valid", if_or.out_valid, 1);
    check("bp_out_b", if_or.q, 8'h02);
    if_or.d = 128'h00000000_00080000_00000000_00000000;
    step();
    check("bp_out_c", if_or.q, 8'h04);
    if_or.in_valid = 1'b0;
    step();
    check("bp_out_d_valid", if_or.out_valid, 1);
    check("bp_out_d", if_or.q, 8'h08);
    step();
    check("bp_empty", if_or.out_valid, 0);

    // Reset with two results in flight.
    if_or.in_valid = 1'b1; if_or.d = 128'h00000000_00000000_00001000_00000000;
    step();
    if_or.d = 128'h00002000_00000000_00000000_00000000;
    step();
    if_or.in_valid = 1'b0;
    check("rs_inflight_valid", if_or.out_valid, 1);
    check("rs_inflight_q", if_or.q, 8'h10);
    #2 resetn = 1'b0;
    #1;
    check("rs_async_valid", if_or.out_valid, 0);
    check("rs_async_q", if_or.q, 0);
    check("rs_async_ready", if_or.in_ready, 1);
    step();
    resetn = 1'b1;
    if_or.in_valid = 1'b1; if_or.d = 128'h40;
    step();
    if_or.in_valid = 1'b0;
    check("rs_after_1", if_or.out_valid, 0);
    step();
    check("rs_after_valid", if_or.out_valid, 1);
    check("rs_after_q", if_or.q, 8'h40);

`ifdef MACRO_REDUCTION_PIPE_FLUSH_EN
    // Flush alongside an accepted input discards it; next input takes 1 cycle.
    if_fl.in_valid = 1'b1; if_fl.d = 8'h5A;
    flush = 1'b1;
    step();
    check("fl_discard_valid", if_fl.out_valid, 0);
    flush = 1'b0;
    if_fl.d = 8'h3C;
    step();
    if_fl.in_valid = 1'b0;
    check("fl_next_valid", if_fl.out_valid, 1);
    check("fl_next_q", if_fl.q, 8'h3C);
    out_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    check("fl_clear_held", if_fl.out_valid, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
